picomips_host: RTL and testbench

Synthesizable host sequencer that drives the picoMips switch interface: it turns one (x, y) request into the SW[8] level-handshake sequence the processor's program expects and captures the two results from LED. It sits between a system-side request port and the processor's `SW[9:0]` and `LED` pins, replacing manual switch operation on the board and in system benches. It has no view of the processor's internal state; it paces every phase with a fixed hold time.

---
 rtl/picomips_host_pkg.sv | 34 +++
 rtl/picomips_host_if.sv | 23 ++
 rtl/picomips_host_hold_timer.sv | 41 ++++
 rtl/picomips_host.sv | 128 ++++++++++++
 tb/tb_picomips_host.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/picomips_host_pkg.sv
// rtl/picomips_host_pkg.sv - shared types and constants for the picoMips switch-interface host
package picomips_host_pkg;

  localparam int MIN_HOLD = 48;
  localparam int SW_RST   = 9;
  localparam int SW_STB   = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    X_HI,
    X_LO,
    Y_HI,
    RX_LO,
    RY_HI,
    FIN_LO
  } host_state_t;

  function automatic host_state_t next_phase(input host_state_t s);
    case (s)
      X_HI:    return X_LO;
      X_LO:    return Y_HI;
      Y_HI:    return RX_LO;
      RX_LO:   return RY_HI;
      RY_HI:   return FIN_LO;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic strobe_level(input host_state_t s);
    return (s == X_HI) || (s == Y_HI) || (s == RY_HI);
  endfunction

endpackage

// File: rtl/picomips_host_if.sv
// rtl/picomips_host_if.sv - request port plus processor SW/LED pins of the host sequencer
interface picomips_host_if;
  logic       start;
  logic       abort;
  logic [7:0] x_in;
  logic [7:0] y_in;
  logic       busy;
  logic       done;
  logic [7:0] x_out;
  logic [7:0] y_out;
  logic [9:0] sw_out;
  logic [7:0] led_in;

  modport master (
    output start, abort, x_in, y_in, led_in,
    input  busy, done, x_out, y_out, sw_out
  );

  modport slave (
    input  start, abort, x_in, y_in, led_in,
    output busy, done, x_out, y_out, sw_out
  );
endinterface

// File: rtl/picomips_host_hold_timer.sv
// rtl/picomips_host_hold_timer.sv - loadable down-counter pacing each SW8 phase
// expired_o pulses in the cycle the count sits at 0, so a phase started by load lasts HOLD cycles.
module hold_timer #(
  parameter int HOLD = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic clear_i,
  output logic expired_o
);
  localparam int CW = $clog2(HOLD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired_q, expired_d;

  always_comb begin
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CW'(HOLD - 1);
    end else if (cnt_q != '0) begin
      cnt_d     = cnt_q - CW'(1);
      expired_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;
endmodule

// File: rtl/picomips_host.sv
// rtl/picomips_host.sv - turns one (x, y) request into the SW8 handshake and captures results from LED
module picomips_host
  import picomips_host_pkg::*;
#(
  parameter int HOLD = 64
) (
  input logic            Clock,
  input logic            nReset,
  picomips_host_if.slave bus
);

  if (HOLD < MIN_HOLD) begin : g_hold_too_short
    $error("picomips_host: HOLD below MIN_HOLD");
  end

  host_state_t state_q, state_d;
  logic [7:0]  x_q, x_d, y_q, y_d;
  logic [7:0]  x_out_q, x_out_d, y_out_q, y_out_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d, done_q, done_d;
  logic        stb_q, stb_d, prst_q, prst_d;
  logic        tmr_load, tmr_clear, tmr_expired;

  hold_timer #(.HOLD(HOLD)) u_hold (
    .clk      (Clock),
    .rst_n    (nReset),
    .load_i   (tmr_load),
    .clear_i  (tmr_clear),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    x_out_d   = x_out_q;
    y_out_d   = y_out_q;
    data_d    = data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    prst_d    = 1'b1;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;

    if (bus.abort) begin
      // Abort always resynchronises the processor; outside IDLE it also drops the transaction.
      prst_d = 1'b0;
      if (state_q != IDLE) begin
        state_d   = IDLE;
        busy_d    = 1'b0;
        data_d    = 8'h00;
        tmr_clear = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            x_d     = bus.x_in;
            y_d     = bus.y_in;
            busy_d  = 1'b1;
            state_d = SETUP;
          end
        end
        SETUP: begin
          state_d  = X_HI;
          tmr_load = 1'b1;
        end
        default: begin
          if (tmr_expired) begin
            if (state_q == RX_LO) x_out_d = bus.led_in;
            if (state_q == RY_HI) y_out_d = bus.led_in;
            if (state_q == FIN_LO) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d  = next_phase(state_q);
              tmr_load = 1'b1;
            end
          end
        end
      endcase
    end

    // SW pins are derived from the next state so the registered pins line up with the phase.
    if (state_d == SETUP || state_d == X_HI) begin
      data_d = x_d;
    end else if (state_d != IDLE) begin
      data_d = y_q;
    end
    stb_d = strobe_level(state_d);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      x_q     <= 8'h00;
      y_q     <= 8'h00;
      x_out_q <= 8'h00;
      y_out_q <= 8'h00;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stb_q   <= 1'b0;
      prst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stb_q   <= stb_d;
      prst_q  <= prst_d;
    end
  end

  assign bus.sw_out[SW_RST]  = prst_q;
  assign bus.sw_out[SW_STB]  = stb_q;
  assign bus.sw_out[7:0]     = data_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.x_out           = x_out_q;
  assign bus.y_out           = y_out_q;

endmodule

// File: tb/tb_picomips_host.sv
// tb/tb_picomips_host.sv - self-checking bench with a behavioural picoMips responder on SW/LED
module tb_picomips_host;
  localparam int HOLD = 64;

  logic Clock;
  logic nReset;
  picomips_host_if bus ();

  picomips_host #(.HOLD(HOLD)) dut (
    .Clock (Clock),
    .nReset(nReset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Processor's affine transform: x' = 0.75x + 0.5y + 20, y' = -0.5x + 0.75y - 20, 8-bit wrap.
  function automatic logic [7:0] model_x(input logic [7:0] x, input logic [7:0] y);
    int xs;
    int ys;
    xs = int'($signed(x));
    ys = int'($signed(y));
    return 8'((3 * xs) / 4 + ys / 2 + 20);
  endfunction

  function automatic logic [7:0] model_y(input logic [7:0] x, input logic [7:0] y);
    int xs;
    int ys;
    xs = int'($signed(x));
    ys = int'($signed(y));
    return 8'((-xs) / 2 + (3 * ys) / 4 - 20);
  endfunction

  // Responder: polls SW8 with a random reaction time, as the program would between HEI points.
  int         p_step = 0;
  int         p_wait = 0;
  logic [7:0] p_x, p_y;

  always @(negedge Clock) begin
    if (!bus.sw_out[9]) begin
      p_step     = 0;
      p_wait     = 0;
      bus.led_in = 8'h00;
    end else if (bus.sw_out[8] == (p_step % 2 == 0)) begin
      if (p_wait > 0) begin
        p_wait--;
      end else begin
        case (p_step)
          0:       p_x = bus.sw_out[7:0];
          2:       p_y = bus.sw_out[7:0];
          3:       bus.led_in = model_x(p_x, p_y);
          4:       bus.led_in = model_y(p_x, p_y);
          default: ;
        endcase
        p_step = (p_step + 1) % 6;
        p_wait = int'($urandom_range(3, 40));
      end
    end
  end

  int         run_len   = 0;
  int         runs[$];
  int         stab_err  = 0;
  int         done_cnt  = 0;
  logic       prev_stb  = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge Clock) begin
    if (bus.sw_out[8]) begin
      run_len++;
    end else if (run_len != 0) begin
      runs.push_back(run_len);
      run_len = 0;
    end
    if (bus.sw_out[8] && prev_stb && bus.sw_out[7:0] != prev_data) stab_err++;
    prev_stb  = bus.sw_out[8];
    prev_data = bus.sw_out[7:0];
    if (bus.done) done_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic accept(input logic [7:0] x, input logic [7:0] y);
    @(negedge Clock);
    bus.start = 1'b1;
    bus.x_in  = x;
    bus.y_in  = y;
    @(negedge Clock);
    bus.start = 1'b0;
    bus.x_in  = 8'($urandom);
    bus.y_in  = 8'($urandom);
  endtask

  task automatic run_txn(input logic [7:0] x, input logic [7:0] y, input int poke_at);
    int         n;
    logic [7:0] ex;
    logic [7:0] ey;
    ex = model_x(x, y);
    ey = model_y(x, y);
    accept(x, y);
    check("setup_busy", 32'(bus.busy), 32'd1);
    check("setup_sw", 32'(bus.sw_out[8:0]), 32'({1'b0, x}));
    n = 1;
    while (!bus.done && n < 1000) begin
      bus.start = (n == poke_at);
      if (n == poke_at) bus.x_in = 8'd5;
      @(negedge Clock);
      n++;
      if (n == HOLD + 2) check("x_lo_sw", 32'(bus.sw_out[8:0]), 32'({1'b0, y}));
    end
    bus.start = 1'b0;
    check("done_latency", 32'(n), 32'(6 * HOLD + 2));
    check("x_out", 32'(bus.x_out), 32'(ex));
    check("y_out", 32'(bus.y_out), 32'(ey));
    @(negedge Clock);
    check("busy_after", 32'(bus.busy), 32'd0);
    check("done_single", 32'(bus.done), 32'd0);
  endtask

  initial begin
    int         ntx;
    int         bad_runs;
    int         dc;
    logic [7:0] sx;
    logic [7:0] sy;
    logic [8:0] ssw;

    ntx       = 0;
    nReset    = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.x_in  = 8'h00;
    bus.y_in  = 8'h00;
    repeat (3) @(negedge Clock);
    check("rst_sw", 32'(bus.sw_out), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_xout", 32'(bus.x_out), 32'd0);
    check("rst_yout", 32'(bus.y_out), 32'd0);
    nReset = 1'b1;
    @(negedge Clock);
    check("sw9_rise", 32'(bus.sw_out[9]), 32'd1);

    run_txn(8'd40, 8'd20, 0);
    ntx++;
    check("basic_x60", 32'(bus.x_out), 32'h3C);
    check("basic_y-25", 32'(bus.y_out), 32'hE7);

    run_txn(8'd0, 8'd0, 0);
    ntx++;
    check("zero_x20", 32'(bus.x_out), 32'h14);
    check("zero_y-20", 32'(bus.y_out), 32'hEC);
    check("zero_data_idle", 32'(bus.sw_out[7:0]), 32'd0);

    dc = done_cnt;
    run_txn(8'd40, 8'd20, 100);
    ntx++;
    repeat (400) @(negedge Clock);
    check("busy_rule_done_cnt", 32'(done_cnt - dc), 32'd1);
    check("busy_rule_x", 32'(bus.x_out), 32'h3C);
    check("busy_rule_idle", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_txn(8'($urandom), 8'($urandom), 0);
      ntx++;
    end

    bad_runs = 0;
    foreach (runs[i]) if (runs[i] != HOLD) bad_runs++;
    check("strobe_runs", 32'(runs.size()), 32'(3 * ntx));
    check("strobe_len", 32'(bad_runs), 32'd0);
    runs.delete();

    // Abort together with start in IDLE: only the processor reset pulses.
    ssw = bus.sw_out[8:0];
    @(negedge Clock);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.x_in  = 8'd7;
    @(negedge Clock);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("idle_abort_sw9", 32'(bus.sw_out[9]), 32'd0);
    check("idle_abort_sw", 32'(bus.sw_out[8:0]), 32'(ssw));
    check("idle_abort_busy", 32'(bus.busy), 32'd0);
    @(negedge Clock);
    check("idle_abort_sw9_back", 32'(bus.sw_out[9]), 32'd1);
    check("idle_abort_still_idle", 32'(bus.busy), 32'd0);

    sx = bus.x_out;
    sy = bus.y_out;
    dc = done_cnt;
    accept(8'd33, 8'd99);
    repeat (2 * HOLD + 10) @(negedge Clock);
    check("yhi_strobe", 32'(bus.sw_out[8]), 32'd1);
    bus.abort = 1'b1;
    @(negedge Clock);
    bus.abort = 1'b0;
    check("abort_sw", 32'(bus.sw_out[8:0]), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_sw9_low", 32'(bus.sw_out[9]), 32'd0);
    @(negedge Clock);
    check("abort_sw9_high", 32'(bus.sw_out[9]), 32'd1);
    repeat (450) @(negedge Clock);
    check("abort_no_done", 32'(done_cnt - dc), 32'd0);
    check("abort_x_kept", 32'(bus.x_out), 32'(sx));
    check("abort_y_kept", 32'(bus.y_out), 32'(sy));
    run_txn(8'd40, 8'd20, 0);
    check("after_abort_x60", 32'(bus.x_out), 32'h3C);
    check("after_abort_y-25", 32'(bus.y_out), 32'hE7);

    accept(8'($urandom), 8'($urandom));
    repeat (3 * HOLD + 10) @(negedge Clock);
    #2 nReset = 1'b0;
    #1;
    check("async_sw", 32'(bus.sw_out), 32'd0);
    check("async_busy", 32'(bus.busy), 32'd0);
    check("async_done", 32'(bus.done), 32'd0);
    check("async_xout", 32'(bus.x_out), 32'd0);
    check("async_yout", 32'(bus.y_out), 32'd0);
    @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
    check("async_sw9_rise", 32'(bus.sw_out[9]), 32'd1);
    run_txn(8'($urandom), 8'($urandom), 0);

    check("data_stable_hi", 32'(stab_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
